// File: rtl/param_seq_fsm.sv
// param_seq_fsm
//   Parametrised sequence generator. A WIDTH-bit register steps through one
//   of four sequences (binary up, binary down, ring, Johnson). It supports a
//   parallel load, an enable, a terminal-count flag and an optional one-shot
//   halt at the terminal value.
//
// Parameters
//   WIDTH     register width, >= 2
//   RESET_VAL value placed in y on reset
//   ONE_SHOT  1: stop at the terminal value and raise done; 0: wrap freely
//
// Ports
//   clk   in   1      clock, rising edge
//   rst   in   1      asynchronous reset, active high
//   en    in   1      advance y one step
//   ld    in   1      load din into y (has priority over en)
//   mode  in   2      00 up, 01 down, 10 ring, 11 Johnson
//   din   in   WIDTH  parallel load value
//   y     out  WIDTH  current sequence value (registered)
//   tc    out  1      y is the terminal value of the current mode
//   done  out  1      FSM is in HALT (registered)
//   busy  out  1      FSM is in RUN (registered)
module param_seq_fsm #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               ONE_SHOT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic [WIDTH-1:0] y_next;
  logic [WIDTH-1:0] step_val;

  // Terminal value of the currently selected mode.
  always_comb begin
    tc = 1'b0;
    unique case (mode)
      2'b00:   tc = (y == '1);
      2'b01:   tc = (y == '0);
      default: tc = (y == MSB_ONE);
    endcase
  end

  // Value y would take on an advance in the current mode.
  always_comb begin
    step_val = y;
    unique case (mode)
      2'b00: step_val = y + LSB_ONE;
      2'b01: step_val = y - LSB_ONE;
      // An all-zero ring would rotate forever as zero; seed a single one.
      2'b10: step_val = (y == '0) ? LSB_ONE : {y[WIDTH-2:0], y[WIDTH-1]};
      2'b11: step_val = {y[WIDTH-2:0], ~y[WIDTH-1]};
      default: step_val = y;
    endcase
  end

  always_comb begin
    state_next = state;
    y_next     = y;
    if (ld) begin
      y_next     = din;
      state_next = RUN;
    end else begin
      unique case (state)
        IDLE: begin
          // The first step out of IDLE never halts, even at terminal.
          if (en) begin
            y_next     = step_val;
            state_next = RUN;
          end
        end
        RUN: begin
          if (en) begin
            if (ONE_SHOT && tc) begin
              state_next = HALT;
            end else begin
              y_next = step_val;
            end
          end
        end
        HALT: state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  // done/busy are registered copies of the next-state decode so they always
  // match the state register without a decode stage after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      y     <= RESET_VAL;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      y     <= y_next;
      done  <= (state_next == HALT);
      busy  <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_param_seq_fsm.sv
module tb_param_seq_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       ld = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] din4 = '0;
  logic [7:0] din8 = '0;

  logic [3:0] y4, yo;
  logic [7:0] y8;
  logic       tc4, done4, busy4;
  logic       tco, doneo, busyo;
  logic       tc8, done8, busy8;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per instance: y value and phase (0 idle, 1 running, 2 halted).
  int m4_y, m4_st, mo_y, mo_st, m8_y, m8_st;

  always #5 clk = ~clk;

  param_seq_fsm #(.WIDTH(4), .RESET_VAL(4'h0), .ONE_SHOT(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .mode(mode), .din(din4),
    .y(y4), .tc(tc4), .done(done4), .busy(busy4));

  param_seq_fsm #(.WIDTH(4), .RESET_VAL(4'h0), .ONE_SHOT(1'b1)) dut_os (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .mode(mode), .din(din4),
    .y(yo), .tc(tco), .done(doneo), .busy(busyo));

  param_seq_fsm #(.WIDTH(8), .RESET_VAL(8'h00), .ONE_SHOT(1'b0)) dut8 (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .mode(mode), .din(din8),
    .y(y8), .tc(tc8), .done(done8), .busy(busy8));

  function automatic int terminal(int w, int md);
    if (md == 0) return (1 << w) - 1;
    if (md == 1) return 0;
    return 1 << (w - 1);
  endfunction

  function automatic int nxt(int w, int md, int v);
    int mask = (1 << w) - 1;
    case (md)
      0: return (v + 1) & mask;
      1: return (v + mask) & mask;
      2: return (v == 0) ? 1 : (((v << 1) | (v >> (w - 1))) & mask);
      default: return ((v << 1) | (((v >> (w - 1)) & 1) ^ 1)) & mask;
    endcase
  endfunction

  task automatic mstep(input int w, input bit os, input int d, inout int v, inout int st);
    if (ld) begin
      v = d; st = 1;
    end else if (en && st != 2) begin
      if (os && st == 1 && v == terminal(w, int'(mode))) st = 2;
      else begin v = nxt(w, int'(mode), v); st = 1; end
    end
  endtask

  task automatic mreset();
    m4_y = 0; m4_st = 0; mo_y = 0; mo_st = 0; m8_y = 0; m8_st = 0;
  endtask

  // One clock edge; the model follows the inputs sampled there.
  task automatic tick();
    @(posedge clk);
    mstep(4, 1'b0, int'(din4), m4_y, m4_st);
    mstep(4, 1'b1, int'(din4), mo_y, mo_st);
    mstep(8, 1'b0, int'(din8), m8_y, m8_st);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; en = 1'b0; ld = 1'b0;
    #2; rst = 1'b0; mreset();
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    mreset();
    #1;
    n_checks++;
    if (y4 !== 4'h0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: y=%h busy=%b done=%b, required y=0 busy=0 done=0", y4, busy4, done4);
    end
    n_checks++;
    if (tc4 !== 1'b0) begin n_fail++; $display("FAIL reset_tc_up: tc=%b required 0", tc4); end
    mode = 2'b01; #1;
    n_checks++;
    if (tc4 !== 1'b1) begin n_fail++; $display("FAIL reset_tc_down: tc=%b required 1", tc4); end
    mode = 2'b00;
    tick();
    n_checks++;
    if (y4 !== 4'h0 || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: y=%h busy=%b required y=0 busy=0", y4, busy4);
    end
  endtask

  task automatic test_up();
    do_reset();
    mode = 2'b00; en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      n_checks++;
      if (y4 !== 4'((i + 1) % 16) || y4 !== 4'(m4_y)) begin
        n_fail++; $display("FAIL up_seq[%0d]: y=%h required %h", i, y4, 4'((i + 1) % 16));
      end
      n_checks++;
      if (tc4 !== (m4_y == 15) || busy4 !== 1'b1) begin
        n_fail++; $display("FAIL up_flags[%0d]: tc=%b busy=%b required tc=%b busy=1", i, tc4, busy4, m4_y == 15);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_ring_johnson();
    logic [3:0] ring_exp [5];
    logic [3:0] john_exp [8];
    ring_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    john_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    for (int m = 2; m <= 3; m++) begin
      mode = 2'(m); ld = 1'b1; din4 = 4'h0; en = 1'b0;
      tick();
      ld = 1'b0; en = 1'b1;
      for (int i = 0; i < ((m == 2) ? 5 : 8); i++) begin
        tick();
        n_checks++;
        if (y4 !== ((m == 2) ? ring_exp[i] : john_exp[i]) || y4 !== 4'(m4_y)) begin
          n_fail++; $display("FAIL mode%0d_seq[%0d]: y=%b required %b", m, i, y4, (m == 2) ? ring_exp[i] : john_exp[i]);
        end
        n_checks++;
        if (tc4 !== (y4 == 4'b1000)) begin
          n_fail++; $display("FAIL mode%0d_tc[%0d]: tc=%b required %b", m, i, tc4, y4 == 4'b1000);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_one_shot();
    do_reset();
    mode = 2'b01; en = 1'b1;
    tick();
    n_checks++;
    if (yo !== 4'hF || doneo !== 1'b0 || busyo !== 1'b1) begin
      n_fail++; $display("FAIL os_first_step: y=%h done=%b busy=%b required y=f done=0 busy=1", yo, doneo, busyo);
    end
    ld = 1'b1; en = 1'b0; din4 = 4'b0011;
    tick();
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (yo !== 4'(2 - i) || tco !== (i == 2) || doneo !== 1'b0) begin
        n_fail++; $display("FAIL os_count[%0d]: y=%h tc=%b done=%b required y=%h tc=%b done=0", i, yo, tco, doneo, 4'(2 - i), i == 2);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (yo !== 4'h0 || doneo !== 1'b1 || busyo !== 1'b0 || mo_st != 2) begin
        n_fail++; $display("FAIL os_halt[%0d]: y=%h done=%b busy=%b required y=0 done=1 busy=0", i, yo, doneo, busyo);
      end
    end
    ld = 1'b1; en = 1'b0; din4 = 4'b0101;
    tick();
    n_checks++;
    if (yo !== 4'b0101 || doneo !== 1'b0 || busyo !== 1'b1) begin
      n_fail++; $display("FAIL os_reload: y=%h done=%b busy=%b required y=5 done=0 busy=1", yo, doneo, busyo);
    end
    din4 = 4'b0000;
    tick();
    n_checks++;
    if (yo !== 4'h0 || doneo !== 1'b0 || busyo !== 1'b1) begin
      n_fail++; $display("FAIL os_load_terminal: y=%h done=%b busy=%b required y=0 done=0 busy=1", yo, doneo, busyo);
    end
    ld = 1'b0; en = 1'b1;
    tick();
    n_checks++;
    if (yo !== 4'h0 || doneo !== 1'b1) begin
      n_fail++; $display("FAIL os_halt_after_load: y=%h done=%b required y=0 done=1", yo, doneo);
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    mode = 2'b00; ld = 1'b1; en = 1'b1; din4 = 4'b1010;
    tick();
    n_checks++;
    if (y4 !== 4'b1010 || y4 !== 4'(m4_y)) begin
      n_fail++; $display("FAIL ld_over_en: y=%b required 1010", y4);
    end
    en = 1'b0; din4 = 4'b0101;
    tick();
    ld = 1'b0; en = 1'b1;
    tick();
    n_checks++;
    if (y4 !== 4'b0110) begin n_fail++; $display("FAIL pre_reset_count: y=%b required 0110", y4); end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (y4 !== 4'h0 || busy4 !== 1'b0 || done4 !== 1'b0 || yo !== 4'h0 || y8 !== 8'h00) begin
      n_fail++; $display("FAIL async_reset: y=%b busy=%b done=%b y_os=%b y8=%h required all zero", y4, busy4, done4, yo, y8);
    end
    #1 rst = 1'b0; en = 1'b0;
    mreset();
  endtask

  task automatic test_width8();
    mode = 2'b00; ld = 1'b1; en = 1'b0; din8 = 8'hFE;
    tick();
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (y8 !== 8'((254 + i + 1) % 256) || tc8 !== (i == 0) || y8 !== 8'(m8_y)) begin
        n_fail++; $display("FAIL w8_step[%0d]: y=%h tc=%b required y=%h tc=%b", i, y8, tc8, 8'((254 + i + 1) % 256), i == 0);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      en   = ($urandom_range(0, 9) < 7);
      ld   = ($urandom_range(0, 9) == 0);
      mode = 2'($urandom_range(0, 3));
      din4 = 4'($urandom);
      din8 = 8'($urandom);
      tick();
      // Mode is perturbed after the edge so tc is also checked against a
      // mode that differs from the one used for the last step.
      if ($urandom_range(0, 3) == 0) begin mode = 2'($urandom_range(0, 3)); #1; end
      n_checks++;
      if (y4 !== 4'(m4_y) || tc4 !== (m4_y == terminal(4, int'(mode))) || busy4 !== (m4_st == 1) || done4 !== 1'b0) begin
        n_fail++; $display("FAIL rnd_w4[%0d]: y=%h tc=%b busy=%b done=%b required y=%h tc=%b busy=%b done=0",
                           i, y4, tc4, busy4, done4, 4'(m4_y), m4_y == terminal(4, int'(mode)), m4_st == 1);
      end
      n_checks++;
      if (yo !== 4'(mo_y) || tco !== (mo_y == terminal(4, int'(mode))) || busyo !== (mo_st == 1) || doneo !== (mo_st == 2)) begin
        n_fail++; $display("FAIL rnd_os[%0d]: y=%h tc=%b busy=%b done=%b required y=%h tc=%b busy=%b done=%b",
                           i, yo, tco, busyo, doneo, 4'(mo_y), mo_y == terminal(4, int'(mode)), mo_st == 1, mo_st == 2);
      end
      n_checks++;
      if (y8 !== 8'(m8_y) || tc8 !== (m8_y == terminal(8, int'(mode))) || busy8 !== (m8_st == 1) || done8 !== 1'b0) begin
        n_fail++; $display("FAIL rnd_w8[%0d]: y=%h tc=%b busy=%b done=%b required y=%h tc=%b busy=%b done=0",
                           i, y8, tc8, busy8, done8, 8'(m8_y), m8_y == terminal(8, int'(mode)), m8_st == 1);
      end
    end
    en = 1'b0; ld = 1'b0;
  endtask

  initial begin
    mreset();
    test_reset();
    test_up();
    test_ring_johnson();
    test_one_shot();
    test_back_to_back();
    test_width8();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
